target_gen_ras: RTL and testbench
=================================

Name: target_gen_ras

Overview:
- Parametrised successor to the execute-stage target generator.
- Computes the branch/jump target (pc+imm, or the ALU result for register-indirect jumps) and the link value (pc+4, or pc+imm when rdsel is set).
- Adds a return-address stack (RAS) that is pushed on calls and popped on returns, with return-misprediction detection.
- Adds one registered valid/ready output stage feeding the fetch redirect logic.

Parameters:
- XLEN, 32, datapath width of pc/imm/alu_result/targets.
- RAS_DEPTH, 8, RAS entries; power of two, 2..64.
- LINK_OFFSET, 4, constant added to pc for the link value.
- CLEAR_JALR_LSB, 1, when 1, force bit0 of the ALU-sourced target to 0.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- io_in_valid  in  1  execute-stage instruction valid.
- io_in_ready  out  1  stage can accept (!out_valid | out_ready).
- io_ex_pc  in  XLEN  instruction pc.
- io_imm  in  XLEN  sign-extended immediate.
- io_alu_result  in  XLEN  rs1+imm for register-indirect jumps.
- io_pcsel  in  1  1: target = alu_result; 0: target = pc+imm.
- io_rdsel  in  1  1: link = pc+imm; 0: link = pc+LINK_OFFSET.
- io_is_call  in  1  push link onto RAS.
- io_is_ret  in  1  pop RAS, compare against target.
- io_flush  in  1  pipeline flush/redirect.
- io_out_valid  out  1  registered result valid.
- io_out_ready  in  1  downstream accepts.
- io_reg_pc  out  XLEN  registered link value.
- io_target_pc  out  XLEN  registered computed target.
- io_ras_target  out  XLEN  registered popped RAS entry (0 if no hit).
- io_ras_hit  out  1  registered: return popped a valid entry.
- io_ras_mispredict  out  1  registered: ras_hit and ras_target != target_pc.
- io_ras_count  out  clog2(RAS_DEPTH)+1  live occupancy.
- io_ras_empty / io_ras_full  out  1  live: count==0 / count==RAS_DEPTH.

Behaviour:
- Reset (async assert, reset==0): all registered outputs 0, count 0, top pointer 0. RAS storage contents are don't-care; the count governs validity.
- Accept occurs when io_in_valid & io_in_ready & !io_flush.
- Latency is one cycle: an accept in cycle N gives io_out_valid=1 in N+1.
- If out_valid & !out_ready, all outputs hold stable and io_in_ready=0.
- Arithmetic: all sums are modulo 2^XLEN, no carry-out.
- target = pcsel ? (alu_result & ~(CLEAR_JALR_LSB)) : pc+imm.
- link = rdsel ? pc+imm : pc+LINK_OFFSET.
- RAS operations occur only on accept:
  - push-only: write link at top+1, increment top (mod depth), count = min(count+1, RAS_DEPTH).
  - Push when full overwrites the oldest entry (circular); count stays RAS_DEPTH.
  - pop-only, count>0: output entry[top], ras_hit=1, decrement top, decrement count.
  - pop-only, count==0: ras_hit=0, ras_target=0, mispredict=0, state unchanged.
  - call and ret together (coroutine swap): pop returns entry[top] with hit rules as above, then link is written at the same top. Count is unchanged if it was >0; if it was 0, count becomes 1.
- Flush has priority over everything:
  - Clears count to 0 and out_valid to 0 at the next edge.
  - The input that cycle is dropped; no RAS update.
- A deasserted reset mid-operation needs no recovery sequence: state is as at reset.
- ras_* registered fields are 0 when the accepted instruction is not a return.

Decomposition:
- Shared package: XLEN default, LINK_OFFSET, and a target_result struct (reg_pc, target_pc, ras_target, ras_hit, ras_mispredict).
- One natural sub-module, ras_stack: circular storage, top pointer, count, and push/pop/swap/clear. Holds no target arithmetic.

Test Plan:
- Reset with clock idle, then release -> all outputs 0, io_ras_empty=1, io_in_ready=1.
- pc=0x1000, imm=0x20, pcsel=0, rdsel=0, valid -> next cycle target=0x1020, reg_pc=0x1004, out_valid=1. Then pcsel=1, alu=0x2003 -> target=0x2002.
- Calls at pc=0x100, 0x200, 0x300, then three rets with matching alu targets -> ras_target 0x304, 0x204, 0x104, hit=1, mispredict=0, count 3→0. A fourth ret -> hit=0.
- Push 9 calls with RAS_DEPTH=8 -> full=1, count=8. Eight pops return the newest eight links, then hit=0 (oldest lost).
- Ret with alu=0x5000 while top=0x304 -> mispredict=1. Call+ret in the same cycle at pc=0x400 -> pops 0x304, top becomes 0x404, count unchanged.
- Hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Flush while count=5 -> count=0 and out_valid=0 next cycle.

Source files
------------

// File: rtl/target_gen_ras_pkg.sv
// -----------------------------------------------------------------------------
// target_gen_ras_pkg
// Shared definitions for the execute-stage target generator with its
// return-address stack: default widths/offsets, and the result record that
// travels from the execute stage to the fetch redirect logic.
// -----------------------------------------------------------------------------
package target_gen_ras_pkg;

   localparam int XLEN_DEF        = 32;
   localparam int RAS_DEPTH_DEF   = 8;
   localparam int LINK_OFFSET_DEF = 4;

   // Result record at the default datapath width. The top builds the same
   // record at its own XLEN; this one is the width-fixed view used by
   // anything that works at the default width.
   typedef struct packed {
      logic [XLEN_DEF-1:0] reg_pc;
      logic [XLEN_DEF-1:0] target_pc;
      logic [XLEN_DEF-1:0] ras_target;
      logic                ras_hit;
      logic                ras_mispredict;
   } target_result_t;

   // Width of an occupancy counter able to hold 0..depth inclusive.
   function automatic int cnt_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/target_gen_ras_ras_stack.sv
// -----------------------------------------------------------------------------
// target_gen_ras_ras_stack
// Circular return-address stack. Pushing onto a full stack overwrites the
// oldest entry; the count (not the storage) decides which entries are valid.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   clear_i           drop all entries (highest priority)
//   push_i, pop_i     push / pop; both together is an in-place swap
//   wdata_i           value to push
//   rdata_o           entry at the current top (the value a pop returns)
//   hit_o             pop_i while the stack holds at least one entry
//   count_o           occupancy, 0..DEPTH
//   empty_o, full_o   count==0 / count==DEPTH
// -----------------------------------------------------------------------------
module target_gen_ras_ras_stack
   import target_gen_ras_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH_DEF,
   parameter int W     = XLEN_DEF
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     hit_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] top_q, top_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  mem_q [DEPTH];
   logic          wr_en;
   logic [PW-1:0] wr_ptr;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign count_o = cnt_q;
   assign rdata_o = mem_q[top_q];
   assign hit_o   = pop_i & ~empty_o;

   always_comb begin
      top_d  = top_q;
      cnt_d  = cnt_q;
      wr_en  = 1'b0;
      wr_ptr = top_q;
      if (clear_i) begin
         top_d = '0;
         cnt_d = '0;
      end else if (push_i && pop_i) begin
         // Swap: the popped slot is reused for the new link, top stays put.
         wr_en = 1'b1;
         if (empty_o) cnt_d = CW'(1);
      end else if (push_i) begin
         // Pointer wraps naturally; on a full stack this lands on the oldest.
         wr_en  = 1'b1;
         wr_ptr = top_q + 1'b1;
         top_d  = top_q + 1'b1;
         if (!full_o) cnt_d = cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
         top_d = top_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         top_q <= '0;
         cnt_q <= '0;
      end else begin
         top_q <= top_d;
         cnt_q <= cnt_d;
      end
   end

   // Storage is not reset; validity comes from the count.
   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr] <= wdata_i;
   end

endmodule

// File: rtl/target_gen_ras.sv
// -----------------------------------------------------------------------------
// target_gen_ras
// Execute-stage branch/jump target generator with a return-address stack and
// one registered valid/ready output stage toward the fetch redirect logic.
//
// Ports:
//   clock, reset                 clock, asynchronous active-low reset
//   io_in_valid / io_in_ready    execute-stage handshake
//   io_ex_pc, io_imm             instruction pc and sign-extended immediate
//   io_alu_result                rs1+imm for register-indirect jumps
//   io_pcsel                     1: target from ALU, 0: pc+imm
//   io_rdsel                     1: link = pc+imm, 0: link = pc+LINK_OFFSET
//   io_is_call, io_is_ret        RAS push / pop (both: swap)
//   io_flush                     drop the input, empty the RAS and output stage
//   io_out_valid / io_out_ready  registered result handshake
//   io_reg_pc, io_target_pc      registered link and target
//   io_ras_target, io_ras_hit,
//   io_ras_mispredict            registered return-prediction results
//   io_ras_count/_empty/_full    live RAS occupancy
// -----------------------------------------------------------------------------
module target_gen_ras
   import target_gen_ras_pkg::*;
#(
   parameter int XLEN           = XLEN_DEF,
   parameter int RAS_DEPTH      = RAS_DEPTH_DEF,
   parameter int LINK_OFFSET    = LINK_OFFSET_DEF,
   parameter int CLEAR_JALR_LSB = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       io_in_valid,
   output logic                       io_in_ready,
   input  logic [XLEN-1:0]            io_ex_pc,
   input  logic [XLEN-1:0]            io_imm,
   input  logic [XLEN-1:0]            io_alu_result,
   input  logic                       io_pcsel,
   input  logic                       io_rdsel,
   input  logic                       io_is_call,
   input  logic                       io_is_ret,
   input  logic                       io_flush,
   output logic                       io_out_valid,
   input  logic                       io_out_ready,
   output logic [XLEN-1:0]            io_reg_pc,
   output logic [XLEN-1:0]            io_target_pc,
   output logic [XLEN-1:0]            io_ras_target,
   output logic                       io_ras_hit,
   output logic                       io_ras_mispredict,
   output logic [$clog2(RAS_DEPTH):0] io_ras_count,
   output logic                       io_ras_empty,
   output logic                       io_ras_full
);

   typedef struct packed {
      logic [XLEN-1:0] reg_pc;
      logic [XLEN-1:0] target_pc;
      logic [XLEN-1:0] ras_target;
      logic            ras_hit;
      logic            ras_mispredict;
   } res_t;

   // Register-indirect targets optionally drop bit 0.
   localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, (CLEAR_JALR_LSB == 0)};

   res_t            res_q, res_d;
   logic            valid_q, valid_d;
   logic            accept;
   logic [XLEN-1:0] sum, target, link;
   logic [XLEN-1:0] ras_rdata;
   logic            ras_hit;

   assign io_in_ready = ~valid_q | io_out_ready;
   assign accept      = io_in_valid & io_in_ready & ~io_flush;

   assign sum    = io_ex_pc + io_imm;
   assign target = io_pcsel ? (io_alu_result & JALR_MASK) : sum;
   assign link   = io_rdsel ? sum : io_ex_pc + XLEN'(LINK_OFFSET);

   target_gen_ras_ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (XLEN)
   ) u_ras (
      .clk_i   (clock),
      .rst_ni  (reset),
      .clear_i (io_flush),
      .push_i  (accept & io_is_call),
      .pop_i   (accept & io_is_ret),
      .wdata_i (link),
      .rdata_o (ras_rdata),
      .hit_o   (ras_hit),
      .count_o (io_ras_count),
      .empty_o (io_ras_empty),
      .full_o  (io_ras_full)
   );

   always_comb begin
      res_d   = res_q;
      valid_d = valid_q;
      if (io_flush)         valid_d = 1'b0;
      else if (io_in_ready) valid_d = accept;

      if (accept) begin
         res_d.reg_pc         = link;
         res_d.target_pc      = target;
         res_d.ras_target     = '0;
         res_d.ras_hit        = 1'b0;
         res_d.ras_mispredict = 1'b0;
         if (io_is_ret && ras_hit) begin
            res_d.ras_target     = ras_rdata;
            res_d.ras_hit        = 1'b1;
            res_d.ras_mispredict = (ras_rdata != target);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         res_q   <= '0;
      end else begin
         valid_q <= valid_d;
         res_q   <= res_d;
      end
   end

   assign io_out_valid      = valid_q;
   assign io_reg_pc         = res_q.reg_pc;
   assign io_target_pc      = res_q.target_pc;
   assign io_ras_target     = res_q.ras_target;
   assign io_ras_hit        = res_q.ras_hit;
   assign io_ras_mispredict = res_q.ras_mispredict;

endmodule

// File: tb/tb_target_gen_ras.sv
// -----------------------------------------------------------------------------
// tb_target_gen_ras
// Directed bench for target_gen_ras (XLEN=32, RAS_DEPTH=8). A queue-based
// model of the return stack and output stage is checked every cycle, and
// hand-computed literals pin key results.
// -----------------------------------------------------------------------------
module tb_target_gen_ras;
   import target_gen_ras_pkg::*;

   localparam int DEPTH = 8;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b0;
   logic        io_in_valid, io_in_ready;
   logic [31:0] io_ex_pc, io_imm, io_alu_result;
   logic        io_pcsel, io_rdsel, io_is_call, io_is_ret, io_flush;
   logic        io_out_valid, io_out_ready;
   logic [31:0] io_reg_pc, io_target_pc, io_ras_target;
   logic        io_ras_hit, io_ras_mispredict;
   logic [3:0]  io_ras_count;
   logic        io_ras_empty, io_ras_full;

   target_gen_ras #(
      .XLEN(32), .RAS_DEPTH(DEPTH), .LINK_OFFSET(4), .CLEAR_JALR_LSB(1)
   ) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
      .io_ex_pc(io_ex_pc), .io_imm(io_imm), .io_alu_result(io_alu_result),
      .io_pcsel(io_pcsel), .io_rdsel(io_rdsel),
      .io_is_call(io_is_call), .io_is_ret(io_is_ret), .io_flush(io_flush),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
      .io_reg_pc(io_reg_pc), .io_target_pc(io_target_pc),
      .io_ras_target(io_ras_target), .io_ras_hit(io_ras_hit),
      .io_ras_mispredict(io_ras_mispredict),
      .io_ras_count(io_ras_count), .io_ras_empty(io_ras_empty),
      .io_ras_full(io_ras_full)
   );

   always #5 if (clk_en) clock = ~clock;

   // Model state: output stage plus the stack as a plain queue (newest last).
   bit             m_valid;
   target_result_t m_res;
   logic [31:0]    m_q[$];

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      if (chk_en) begin
         cmp("out_valid", 32'(io_out_valid), 32'(m_valid));
         cmp("in_ready", 32'(io_in_ready), 32'(!m_valid || io_out_ready));
         cmp("ras_count", 32'(io_ras_count), 32'(m_q.size()));
         cmp("ras_empty", 32'(io_ras_empty), 32'(m_q.size() == 0));
         cmp("ras_full", 32'(io_ras_full), 32'(m_q.size() == DEPTH));
         if (m_valid) begin
            cmp("reg_pc", io_reg_pc, m_res.reg_pc);
            cmp("target_pc", io_target_pc, m_res.target_pc);
            cmp("ras_target", io_ras_target, m_res.ras_target);
            cmp("ras_hit", 32'(io_ras_hit), 32'(m_res.ras_hit));
            cmp("ras_mispredict", 32'(io_ras_mispredict), 32'(m_res.ras_mispredict));
         end
      end
   end

   task automatic idle_inputs();
      io_in_valid = 0; io_ex_pc = 0; io_imm = 0; io_alu_result = 0;
      io_pcsel = 0; io_rdsel = 0; io_is_call = 0; io_is_ret = 0; io_flush = 0;
   endtask

   // Advance one clock: evaluate the model from the inputs present at the
   // edge, commit it after the edge, then return inputs to idle.
   task automatic tick();
      bit             rdy, acc, nv;
      logic [31:0]    tgt, link;
      target_result_t r;
      logic [31:0]    q[$];
      q   = m_q;
      r   = m_res;
      nv  = m_valid;
      rdy = !m_valid || io_out_ready;
      acc = io_in_valid && rdy && !io_flush;
      if (io_flush) begin
         nv = 0;
         q.delete();
      end else if (rdy) begin
         nv = acc;
      end
      if (acc) begin
         tgt  = io_pcsel ? (io_alu_result & 32'hFFFF_FFFE) : io_ex_pc + io_imm;
         link = io_rdsel ? io_ex_pc + io_imm : io_ex_pc + 32'd4;
         r.reg_pc = link;
         r.target_pc = tgt;
         r.ras_target = 0;
         r.ras_hit = 0;
         r.ras_mispredict = 0;
         if (io_is_ret && q.size() > 0) begin
            r.ras_target = q[$];
            void'(q.pop_back());
            r.ras_hit = 1;
            r.ras_mispredict = (r.ras_target != tgt);
         end
         if (io_is_call) begin
            q.push_back(link);
            if (q.size() > DEPTH) void'(q.pop_front());
         end
      end
      @(posedge clock);
      m_valid = nv;
      m_res   = r;
      m_q     = q;
      #1;
      idle_inputs();
   endtask

   task automatic op(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] alu,
                     input bit pcsel, input bit rdsel, input bit call, input bit ret);
      io_in_valid = 1; io_ex_pc = pc; io_imm = imm; io_alu_result = alu;
      io_pcsel = pcsel; io_rdsel = rdsel; io_is_call = call; io_is_ret = ret;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] k32;
      idle_inputs();
      io_out_ready = 1;
      m_valid = 0;
      m_res   = '0;

      // Reset with the clock idle.
      #1 reset = 0;
      #10;
      cmp("rst out_valid", 32'(io_out_valid), 32'd0);
      cmp("rst reg_pc", io_reg_pc, 32'd0);
      cmp("rst target_pc", io_target_pc, 32'd0);
      cmp("rst ras_target", io_ras_target, 32'd0);
      cmp("rst ras_hit", 32'(io_ras_hit), 32'd0);
      cmp("rst ras_mispredict", 32'(io_ras_mispredict), 32'd0);
      cmp("rst count", 32'(io_ras_count), 32'd0);
      cmp("rst empty", 32'(io_ras_empty), 32'd1);
      cmp("rst full", 32'(io_ras_full), 32'd0);
      cmp("rst in_ready", 32'(io_in_ready), 32'd1);
      reset = 1;
      #2 clk_en = 1;
      chk_en = 1;

      // Basic target/link arithmetic.
      op(32'h1000, 32'h20, 32'h0, 0, 0, 0, 0);
      cmp("lit target pc+imm", io_target_pc, 32'h1020);
      cmp("lit link pc+4", io_reg_pc, 32'h1004);
      cmp("lit out_valid", 32'(io_out_valid), 32'd1);
      op(32'h1000, 32'h20, 32'h2003, 1, 0, 0, 0);
      cmp("lit jalr lsb", io_target_pc, 32'h2002);
      op(32'h1000, 32'h20, 32'h0, 0, 1, 0, 0);
      cmp("lit link rdsel", io_reg_pc, 32'h1020);

      // Three calls then matching returns.
      op(32'h100, 32'h40, 32'h0, 0, 0, 1, 0);
      op(32'h200, 32'h40, 32'h0, 0, 0, 1, 0);
      op(32'h300, 32'h40, 32'h0, 0, 0, 1, 0);
      cmp("lit count 3", 32'(io_ras_count), 32'd3);
      op(32'h380, 32'h0, 32'h304, 1, 0, 0, 1);
      cmp("lit ret1", io_ras_target, 32'h304);
      cmp("lit ret1 hit", 32'(io_ras_hit), 32'd1);
      cmp("lit ret1 mis", 32'(io_ras_mispredict), 32'd0);
      op(32'h380, 32'h0, 32'h204, 1, 0, 0, 1);
      cmp("lit ret2", io_ras_target, 32'h204);
      op(32'h380, 32'h0, 32'h104, 1, 0, 0, 1);
      cmp("lit ret3", io_ras_target, 32'h104);
      cmp("lit count 0", 32'(io_ras_count), 32'd0);
      op(32'h380, 32'h0, 32'h104, 1, 0, 0, 1);
      cmp("lit ret4 hit", 32'(io_ras_hit), 32'd0);
      cmp("lit ret4 target", io_ras_target, 32'd0);

      // Overflow: nine calls into eight entries.
      for (int k = 1; k <= 9; k++) begin
         k32 = 32'(k) << 12;
         op(k32, 32'h8, 32'h0, 0, 0, 1, 0);
      end
      cmp("lit full", 32'(io_ras_full), 32'd1);
      cmp("lit count 8", 32'(io_ras_count), 32'd8);
      for (int k = 9; k >= 2; k--) begin
         k32 = (32'(k) << 12) | 32'h4;
         op(32'h10, 32'h0, k32, 1, 0, 0, 1);
         cmp("lit ovf pop", io_ras_target, k32);
      end
      op(32'h10, 32'h0, 32'h1004, 1, 0, 0, 1);
      cmp("lit oldest lost", 32'(io_ras_hit), 32'd0);

      // Mispredict, then call+ret swap.
      op(32'h100, 32'h0, 32'h0, 0, 0, 1, 0);
      op(32'h200, 32'h0, 32'h0, 0, 0, 1, 0);
      op(32'h300, 32'h0, 32'h0, 0, 0, 1, 0);
      op(32'h380, 32'h0, 32'h5000, 1, 0, 0, 1);
      cmp("lit mispredict", 32'(io_ras_mispredict), 32'd1);
      cmp("lit mis target", io_ras_target, 32'h304);
      op(32'h300, 32'h0, 32'h0, 0, 0, 1, 0);
      op(32'h400, 32'h8, 32'h304, 1, 0, 1, 1);
      cmp("lit swap pop", io_ras_target, 32'h304);
      cmp("lit swap link", io_reg_pc, 32'h404);
      cmp("lit swap count", 32'(io_ras_count), 32'd3);
      op(32'h480, 32'h0, 32'h404, 1, 0, 0, 1);
      cmp("lit swap top", io_ras_target, 32'h404);

      // Swap on an empty stack seeds one entry.
      op(32'h10, 32'h0, 32'h0, 1, 0, 0, 1);
      op(32'h10, 32'h0, 32'h0, 1, 0, 0, 1);
      op(32'h600, 32'h0, 32'h0, 1, 0, 1, 1);
      cmp("lit swap empty hit", 32'(io_ras_hit), 32'd0);
      cmp("lit swap empty count", 32'(io_ras_count), 32'd1);

      // Back-pressure: outputs hold while out_ready is low.
      op(32'h7000, 32'h10, 32'h0, 0, 0, 0, 0);
      io_out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         io_in_valid = 1; io_ex_pc = 32'h8000; io_is_call = 1;
         tick();
         cmp("lit hold target", io_target_pc, 32'h7010);
         cmp("lit hold in_ready", 32'(io_in_ready), 32'd0);
         cmp("lit hold count", 32'(io_ras_count), 32'd1);
      end
      io_out_ready = 1;
      tick();
      cmp("lit drain", 32'(io_out_valid), 32'd0);

      // Flush while count=5.
      for (int i = 0; i < 4; i++) op(32'hA000 + 32'(i) * 32'h100, 32'h0, 32'h0, 0, 0, 1, 0);
      cmp("lit count 5", 32'(io_ras_count), 32'd5);
      io_in_valid = 1; io_ex_pc = 32'h9000; io_is_call = 1; io_flush = 1;
      tick();
      cmp("lit flush count", 32'(io_ras_count), 32'd0);
      cmp("lit flush valid", 32'(io_out_valid), 32'd0);
      op(32'h10, 32'h0, 32'h0, 1, 0, 0, 1);
      cmp("lit after flush hit", 32'(io_ras_hit), 32'd0);
      tick();
      tick();

      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
